// File: rtl/control_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : control_pkg
//  Description : Shared opcodes, ALU-select bit indices, instruction field
//                positions and sequencer state encodings for the hardwired
//                control unit.
//  Revision    : 1.0  initial release
// ============================================================================
package control_pkg;

    // Instruction field MSB positions (fields are taken MSB-down)
    localparam int c_OPC_MSB = 31;
    localparam int c_RA_MSB  = 26;
    localparam int c_RB_MSB  = 22;
    localparam int c_RC_MSB  = 18;

    // Supported opcodes; every other code is treated as illegal
    localparam logic [4:0] c_OPC_ADD  = 5'b00000;
    localparam logic [4:0] c_OPC_SUB  = 5'b00001;
    localparam logic [4:0] c_OPC_AND  = 5'b00010;
    localparam logic [4:0] c_OPC_OR   = 5'b00011;
    localparam logic [4:0] c_OPC_SHR  = 5'b00100;
    localparam logic [4:0] c_OPC_SHRA = 5'b00101;
    localparam logic [4:0] c_OPC_SHL  = 5'b00110;
    localparam logic [4:0] c_OPC_ROR  = 5'b00111;
    localparam logic [4:0] c_OPC_ROL  = 5'b01000;
    localparam logic [4:0] c_OPC_NEG  = 5'b01001;
    localparam logic [4:0] c_OPC_NOT  = 5'b01010;
    localparam logic [4:0] c_OPC_MUL  = 5'b01100;
    localparam logic [4:0] c_OPC_DIV  = 5'b01101;

    // One-hot ALU select bit indices; bit 0 is reserved and never driven
    localparam int c_ALU_W    = 14;
    localparam int c_ALU_RSVD = 0;
    localparam int c_ALU_ADD  = 1;
    localparam int c_ALU_SUB  = 2;
    localparam int c_ALU_AND  = 3;
    localparam int c_ALU_OR   = 4;
    localparam int c_ALU_SHR  = 5;
    localparam int c_ALU_SHRA = 6;
    localparam int c_ALU_SHL  = 7;
    localparam int c_ALU_ROR  = 8;
    localparam int c_ALU_ROL  = 9;
    localparam int c_ALU_NEG  = 10;
    localparam int c_ALU_NOT  = 11;
    localparam int c_ALU_MUL  = 12;
    localparam int c_ALU_DIV  = 13;

    // Sequencer states, exported unchanged on state_dbg
    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_HALT = 4'd15
    } state_t;

    // Map an opcode to its one-hot ALU select; unsupported codes give zero
    function automatic logic [c_ALU_W-1:0] alu_select(input logic [4:0] opc);
        logic [c_ALU_W-1:0] sel;
        sel = '0;
        case (opc)
            c_OPC_ADD:  sel[c_ALU_ADD]  = 1'b1;
            c_OPC_SUB:  sel[c_ALU_SUB]  = 1'b1;
            c_OPC_AND:  sel[c_ALU_AND]  = 1'b1;
            c_OPC_OR:   sel[c_ALU_OR]   = 1'b1;
            c_OPC_SHR:  sel[c_ALU_SHR]  = 1'b1;
            c_OPC_SHRA: sel[c_ALU_SHRA] = 1'b1;
            c_OPC_SHL:  sel[c_ALU_SHL]  = 1'b1;
            c_OPC_ROR:  sel[c_ALU_ROR]  = 1'b1;
            c_OPC_ROL:  sel[c_ALU_ROL]  = 1'b1;
            c_OPC_NEG:  sel[c_ALU_NEG]  = 1'b1;
            c_OPC_NOT:  sel[c_ALU_NOT]  = 1'b1;
            c_OPC_MUL:  sel[c_ALU_MUL]  = 1'b1;
            c_OPC_DIV:  sel[c_ALU_DIV]  = 1'b1;
            default:    sel = '0;
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_sel_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : reg_sel_decoder
//  Description : Register-field to one-hot decoder with enable; all outputs
//                are zero when the enable is low.
//  Revision    : 1.0  initial release
// ============================================================================
module reg_sel_decoder #(
    parameter int SEL_W    = 4,
    parameter int NUM_REGS = 16
) (
    input  logic [SEL_W-1:0]    i_sel,
    input  logic                i_en,
    output logic [NUM_REGS-1:0] o_onehot
);

    // One comparator per register so at most one bit can ever be set
    genvar k;
    generate
        for (k = 0; k < NUM_REGS; k = k + 1) begin : g_bit
            assign o_onehot[k] = i_en && (i_sel == SEL_W'(k));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/alu_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_control_sequencer
//  Description : Hardwired control unit. Fetches (T0-T2), decodes IR and
//                sequences register-register ALU instructions (T3-T6),
//                driving every datapath strobe from state and IR.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_control_sequencer
    import control_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int OPC_W    = 5,
    parameter int SEL_W    = 4
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                run,
    input  logic                mem_ready,
    input  logic [31:0]         IR,
    output logic [NUM_REGS-1:0] R_in,
    output logic [NUM_REGS-1:0] R_out,
    output logic                PCout,
    output logic                PCin,
    output logic                IncPC,
    output logic                MARin,
    output logic                MDRin,
    output logic                MDRout,
    output logic                Read,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                HIin,
    output logic                LOin,
    output logic [13:0]         alu_op,
    output logic                done,
    output logic                illegal,
    output logic [3:0]          state_dbg
);

    state_t             r_state;
    state_t             w_next;
    logic               r_illegal;
    logic               w_set_illegal;

    logic [OPC_W-1:0]   w_opc;
    logic [SEL_W-1:0]   w_ra;
    logic [SEL_W-1:0]   w_rb;
    logic [SEL_W-1:0]   w_rc;
    logic               w_is_3op;
    logic               w_is_unary;
    logic               w_is_muldiv;
    logic               w_legal;
    logic [13:0]        w_alu_sel;

    logic               w_in_en;
    logic [SEL_W-1:0]   w_in_sel;
    logic               w_out_en;
    logic [SEL_W-1:0]   w_out_sel;
    logic               w_unused;

    assign w_opc = IR[c_OPC_MSB -: OPC_W];
    assign w_ra  = IR[c_RA_MSB  -: SEL_W];
    assign w_rb  = IR[c_RB_MSB  -: SEL_W];
    assign w_rc  = IR[c_RC_MSB  -: SEL_W];

    // Low IR bits carry no meaning for register-register instructions
    assign w_unused = ^IR[c_RC_MSB-SEL_W:0];

    assign w_is_3op    = (w_opc <= c_OPC_ROL);
    assign w_is_unary  = (w_opc == c_OPC_NEG) || (w_opc == c_OPC_NOT);
    assign w_is_muldiv = (w_opc == c_OPC_MUL) || (w_opc == c_OPC_DIV);
    assign w_legal     = w_is_3op || w_is_unary || w_is_muldiv;
    assign w_alu_sel   = alu_select(w_opc);

    assign illegal   = r_illegal;
    assign state_dbg = r_state;

    reg_sel_decoder #(.SEL_W(SEL_W), .NUM_REGS(NUM_REGS)) u_rin_dec (
        .i_sel    (w_in_sel),
        .i_en     (w_in_en),
        .o_onehot (R_in)
    );

    reg_sel_decoder #(.SEL_W(SEL_W), .NUM_REGS(NUM_REGS)) u_rout_dec (
        .i_sel    (w_out_sel),
        .i_en     (w_out_en),
        .o_onehot (R_out)
    );

    // State register and sticky illegal flag; clear forces IDLE at once
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state   <= ST_IDLE;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // Next-state and strobe decode from the current step and IR opcode class
    always_comb begin
        w_next        = r_state;
        w_set_illegal = 1'b0;
        w_in_en       = 1'b0;
        w_in_sel      = w_ra;
        w_out_en      = 1'b0;
        w_out_sel     = w_rb;
        PCout         = 1'b0;
        PCin          = 1'b0;
        IncPC         = 1'b0;
        MARin         = 1'b0;
        MDRin         = 1'b0;
        MDRout        = 1'b0;
        Read          = 1'b0;
        IRin          = 1'b0;
        Yin           = 1'b0;
        Zin           = 1'b0;
        Zlowout       = 1'b0;
        Zhighout      = 1'b0;
        HIin          = 1'b0;
        LOin          = 1'b0;
        alu_op        = '0;
        done          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (run) begin
                    w_next = ST_T0;
                end
            end
            ST_T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                Zin    = 1'b1;
                w_next = ST_T1;
            end
            ST_T1: begin
                // PC and MDR load only on the exit cycle so a long memory
                // wait still advances PC exactly once
                Zlowout = 1'b1;
                Read    = 1'b1;
                if (mem_ready) begin
                    PCin   = 1'b1;
                    MDRin  = 1'b1;
                    w_next = ST_T2;
                end
            end
            ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
                w_next = ST_T3;
            end
            ST_T3: begin
                if (!w_legal) begin
                    w_set_illegal = 1'b1;
                    w_next        = ST_HALT;
                end else if (w_is_muldiv) begin
                    w_out_en  = 1'b1;
                    w_out_sel = w_ra;
                    Yin       = 1'b1;
                    w_next    = ST_T4;
                end else if (w_is_unary) begin
                    w_out_en  = 1'b1;
                    w_out_sel = w_rb;
                    alu_op    = w_alu_sel;
                    Zin       = 1'b1;
                    w_next    = ST_T4;
                end else begin
                    w_out_en  = 1'b1;
                    w_out_sel = w_rb;
                    Yin       = 1'b1;
                    w_next    = ST_T4;
                end
            end
            ST_T4: begin
                if (w_is_unary) begin
                    Zlowout = 1'b1;
                    w_in_en = 1'b1;
                    done    = 1'b1;
                    w_next  = run ? ST_T0 : ST_IDLE;
                end else begin
                    w_out_en  = 1'b1;
                    w_out_sel = w_is_muldiv ? w_rb : w_rc;
                    alu_op    = w_alu_sel;
                    Zin       = 1'b1;
                    w_next    = ST_T5;
                end
            end
            ST_T5: begin
                Zlowout = 1'b1;
                if (w_is_muldiv) begin
                    LOin   = 1'b1;
                    w_next = ST_T6;
                end else begin
                    w_in_en = 1'b1;
                    done    = 1'b1;
                    w_next  = run ? ST_T0 : ST_IDLE;
                end
            end
            ST_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                done     = 1'b1;
                w_next   = run ? ST_T0 : ST_IDLE;
            end
            ST_HALT: begin
                w_next = ST_HALT;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_control_sequencer
//  Description : Directed self-checking bench for the hardwired control unit.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_control_sequencer;
    import control_pkg::*;

    // Strobe positions inside the packed observation vector
    localparam logic [13:0] c_PCOUT  = 14'h2000;
    localparam logic [13:0] c_PCIN   = 14'h1000;
    localparam logic [13:0] c_INCPC  = 14'h0800;
    localparam logic [13:0] c_MARIN  = 14'h0400;
    localparam logic [13:0] c_MDRIN  = 14'h0200;
    localparam logic [13:0] c_MDROUT = 14'h0100;
    localparam logic [13:0] c_READ   = 14'h0080;
    localparam logic [13:0] c_IRIN   = 14'h0040;
    localparam logic [13:0] c_YIN    = 14'h0020;
    localparam logic [13:0] c_ZIN    = 14'h0010;
    localparam logic [13:0] c_ZLO    = 14'h0008;
    localparam logic [13:0] c_ZHI    = 14'h0004;
    localparam logic [13:0] c_HIIN   = 14'h0002;
    localparam logic [13:0] c_LOIN   = 14'h0001;

    localparam logic [13:0] c_F0 = c_PCOUT | c_MARIN | c_INCPC | c_ZIN;
    localparam logic [13:0] c_F1 = c_ZLO | c_READ | c_PCIN | c_MDRIN;
    localparam logic [13:0] c_FW = c_ZLO | c_READ;
    localparam logic [13:0] c_F2 = c_MDROUT | c_IRIN;

    logic        clock;
    logic        clear;
    logic        run;
    logic        mem_ready;
    logic [31:0] IR;
    logic [15:0] R_in;
    logic [15:0] R_out;
    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin;
    logic        Yin, Zin, Zlowout, Zhighout, HIin, LOin;
    logic [13:0] alu_op;
    logic        done;
    logic        illegal;
    logic [3:0]  state_dbg;

    int n_checks;
    int n_pass;

    logic [65:0] obs;
    assign obs = {R_in, R_out,
                  PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin,
                  Yin, Zin, Zlowout, Zhighout, HIin, LOin,
                  alu_op, done, illegal, state_dbg};

    alu_control_sequencer dut (
        .clock     (clock),
        .clear     (clear),
        .run       (run),
        .mem_ready (mem_ready),
        .IR        (IR),
        .R_in      (R_in),
        .R_out     (R_out),
        .PCout     (PCout),
        .PCin      (PCin),
        .IncPC     (IncPC),
        .MARin     (MARin),
        .MDRin     (MDRin),
        .MDRout    (MDRout),
        .Read      (Read),
        .IRin      (IRin),
        .Yin       (Yin),
        .Zin       (Zin),
        .Zlowout   (Zlowout),
        .Zhighout  (Zhighout),
        .HIin      (HIin),
        .LOin      (LOin),
        .alu_op    (alu_op),
        .done      (done),
        .illegal   (illegal),
        .state_dbg (state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [65:0] ev(input logic [15:0] rin, input logic [15:0] rout,
                                       input logic [13:0] strb, input logic [13:0] alu,
                                       input logic d, input logic ill, input logic [3:0] st);
        return {rin, rout, strb, alu, d, ill, st};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Asynchronous clear in the middle of an ADD, then idle with run low
    task automatic test_reset();
        logic [65:0] e;
        clear = 1'b0; run = 1'b0; mem_ready = 1'b1; IR = 32'h0091_8000;
        tick();
        n_checks++;
        if (obs !== ev(16'h0, 16'h0, 14'h0, 14'h0, 1'b0, 1'b0, ST_IDLE))
            $display("FAIL reset_state: got %h want %h", obs,
                     ev(16'h0, 16'h0, 14'h0, 14'h0, 1'b0, 1'b0, ST_IDLE));
        else n_pass++;
        clear = 1'b1;
        tick();
        run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) run = 1'b0;
        end
        e = ev(16'h0, 16'h0008, c_ZIN, 14'h0002, 1'b0, 1'b0, ST_T4);
        n_checks++;
        if (obs !== e) $display("FAIL add_t4: got %h want %h", obs, e);
        else n_pass++;
        #2 clear = 1'b0;
        #1;
        e = ev(16'h0, 16'h0, 14'h0, 14'h0, 1'b0, 1'b0, ST_IDLE);
        n_checks++;
        if (obs !== e) $display("FAIL async_clear: got %h want %h", obs, e);
        else n_pass++;
        #1 clear = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (obs !== e) $display("FAIL post_clear cycle %0d: got %h want %h", i, obs, e);
            else n_pass++;
        end
    endtask

    // OR R2,R5,R6 with memory ready immediately
    task automatic test_or_exec();
        logic [65:0] tab [7];
        tab[0] = ev(16'h0,    16'h0,    c_F0,          14'h0,    1'b0, 1'b0, ST_T0);
        tab[1] = ev(16'h0,    16'h0,    c_F1,          14'h0,    1'b0, 1'b0, ST_T1);
        tab[2] = ev(16'h0,    16'h0,    c_F2,          14'h0,    1'b0, 1'b0, ST_T2);
        tab[3] = ev(16'h0,    16'h0020, c_YIN,         14'h0,    1'b0, 1'b0, ST_T3);
        tab[4] = ev(16'h0,    16'h0040, c_ZIN,         14'h0010, 1'b0, 1'b0, ST_T4);
        tab[5] = ev(16'h0004, 16'h0,    c_ZLO,         14'h0,    1'b1, 1'b0, ST_T5);
        tab[6] = ev(16'h0,    16'h0,    14'h0,         14'h0,    1'b0, 1'b0, ST_IDLE);
        IR = 32'h192B_0000; mem_ready = 1'b1; run = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i == 0) run = 1'b0;
            n_checks++;
            if (obs !== tab[i]) $display("FAIL or_exec cycle %0d: got %h want %h", i, obs, tab[i]);
            else n_pass++;
        end
    endtask

    // Memory wait: three not-ready cycles stretch T1 to four cycles
    task automatic test_mem_wait();
        logic [65:0] tab [10];
        logic        mr  [10];
        int          pcin_seen;
        int          mdrin_seen;
        pcin_seen = 0; mdrin_seen = 0;
        tab[0] = ev(16'h0,    16'h0,    c_F0,  14'h0,    1'b0, 1'b0, ST_T0);   mr[0] = 1'b0;
        tab[1] = ev(16'h0,    16'h0,    c_FW,  14'h0,    1'b0, 1'b0, ST_T1);   mr[1] = 1'b0;
        tab[2] = ev(16'h0,    16'h0,    c_FW,  14'h0,    1'b0, 1'b0, ST_T1);   mr[2] = 1'b0;
        tab[3] = ev(16'h0,    16'h0,    c_FW,  14'h0,    1'b0, 1'b0, ST_T1);   mr[3] = 1'b0;
        tab[4] = ev(16'h0,    16'h0,    c_F1,  14'h0,    1'b0, 1'b0, ST_T1);   mr[4] = 1'b1;
        tab[5] = ev(16'h0,    16'h0,    c_F2,  14'h0,    1'b0, 1'b0, ST_T2);   mr[5] = 1'b1;
        tab[6] = ev(16'h0,    16'h0020, c_YIN, 14'h0,    1'b0, 1'b0, ST_T3);   mr[6] = 1'b1;
        tab[7] = ev(16'h0,    16'h0040, c_ZIN, 14'h0010, 1'b0, 1'b0, ST_T4);   mr[7] = 1'b1;
        tab[8] = ev(16'h0004, 16'h0,    c_ZLO, 14'h0,    1'b1, 1'b0, ST_T5);   mr[8] = 1'b1;
        tab[9] = ev(16'h0,    16'h0,    14'h0, 14'h0,    1'b0, 1'b0, ST_IDLE); mr[9] = 1'b1;
        IR = 32'h192B_0000; mem_ready = 1'b0; run = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            run = 1'b0;
            mem_ready = mr[i];
            #1;
            if (PCin === 1'b1) pcin_seen++;
            if (MDRin === 1'b1) mdrin_seen++;
            n_checks++;
            if (obs !== tab[i]) $display("FAIL mem_wait cycle %0d: got %h want %h", i, obs, tab[i]);
            else n_pass++;
        end
        n_checks++;
        if (pcin_seen !== 1) $display("FAIL pc_once: got %0d PCin cycles want 1", pcin_seen);
        else n_pass++;
        n_checks++;
        if (mdrin_seen !== 1) $display("FAIL mdr_once: got %0d MDRin cycles want 1", mdrin_seen);
        else n_pass++;
    endtask

    // MUL R3,R4: LO then HI, no register write
    task automatic test_mul();
        logic [65:0] tab [8];
        tab[0] = ev(16'h0, 16'h0,    c_F0,             14'h0,    1'b0, 1'b0, ST_T0);
        tab[1] = ev(16'h0, 16'h0,    c_F1,             14'h0,    1'b0, 1'b0, ST_T1);
        tab[2] = ev(16'h0, 16'h0,    c_F2,             14'h0,    1'b0, 1'b0, ST_T2);
        tab[3] = ev(16'h0, 16'h0008, c_YIN,            14'h0,    1'b0, 1'b0, ST_T3);
        tab[4] = ev(16'h0, 16'h0010, c_ZIN,            14'h1000, 1'b0, 1'b0, ST_T4);
        tab[5] = ev(16'h0, 16'h0,    c_ZLO | c_LOIN,   14'h0,    1'b0, 1'b0, ST_T5);
        tab[6] = ev(16'h0, 16'h0,    c_ZHI | c_HIIN,   14'h0,    1'b1, 1'b0, ST_T6);
        tab[7] = ev(16'h0, 16'h0,    14'h0,            14'h0,    1'b0, 1'b0, ST_IDLE);
        IR = 32'h61A0_0000; mem_ready = 1'b1; run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) run = 1'b0;
            n_checks++;
            if (obs !== tab[i]) $display("FAIL mul cycle %0d: got %h want %h", i, obs, tab[i]);
            else n_pass++;
        end
    endtask

    // NEG R1,R7 immediately followed by AND R2,R5,R6 with run held high
    task automatic test_back_to_back();
        logic [65:0] tab [12];
        int          dones;
        dones = 0;
        tab[0]  = ev(16'h0,    16'h0,    c_F0,  14'h0,    1'b0, 1'b0, ST_T0);
        tab[1]  = ev(16'h0,    16'h0,    c_F1,  14'h0,    1'b0, 1'b0, ST_T1);
        tab[2]  = ev(16'h0,    16'h0,    c_F2,  14'h0,    1'b0, 1'b0, ST_T2);
        tab[3]  = ev(16'h0,    16'h0080, c_ZIN, 14'h0400, 1'b0, 1'b0, ST_T3);
        tab[4]  = ev(16'h0002, 16'h0,    c_ZLO, 14'h0,    1'b1, 1'b0, ST_T4);
        tab[5]  = ev(16'h0,    16'h0,    c_F0,  14'h0,    1'b0, 1'b0, ST_T0);
        tab[6]  = ev(16'h0,    16'h0,    c_F1,  14'h0,    1'b0, 1'b0, ST_T1);
        tab[7]  = ev(16'h0,    16'h0,    c_F2,  14'h0,    1'b0, 1'b0, ST_T2);
        tab[8]  = ev(16'h0,    16'h0020, c_YIN, 14'h0,    1'b0, 1'b0, ST_T3);
        tab[9]  = ev(16'h0,    16'h0040, c_ZIN, 14'h0008, 1'b0, 1'b0, ST_T4);
        tab[10] = ev(16'h0004, 16'h0,    c_ZLO, 14'h0,    1'b1, 1'b0, ST_T5);
        tab[11] = ev(16'h0,    16'h0,    14'h0, 14'h0,    1'b0, 1'b0, ST_IDLE);
        IR = 32'h48B8_0000; mem_ready = 1'b1; run = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) dones++;
            n_checks++;
            if (obs !== tab[i]) $display("FAIL back_to_back cycle %0d: got %h want %h", i, obs, tab[i]);
            else n_pass++;
            if (i == 5) begin
                IR  = 32'h112B_0000;
                run = 1'b0;
            end
        end
        n_checks++;
        if (dones !== 2) $display("FAIL done_pulses: got %0d want 2", dones);
        else n_pass++;
    endtask

    // Illegal opcode halts with a sticky flag until clear
    task automatic test_illegal();
        logic [65:0] tab [7];
        logic [65:0] e;
        tab[0] = ev(16'h0, 16'h0, c_F0,  14'h0, 1'b0, 1'b0, ST_T0);
        tab[1] = ev(16'h0, 16'h0, c_F1,  14'h0, 1'b0, 1'b0, ST_T1);
        tab[2] = ev(16'h0, 16'h0, c_F2,  14'h0, 1'b0, 1'b0, ST_T2);
        tab[3] = ev(16'h0, 16'h0, 14'h0, 14'h0, 1'b0, 1'b0, ST_T3);
        tab[4] = ev(16'h0, 16'h0, 14'h0, 14'h0, 1'b0, 1'b1, ST_HALT);
        tab[5] = ev(16'h0, 16'h0, 14'h0, 14'h0, 1'b0, 1'b1, ST_HALT);
        tab[6] = ev(16'h0, 16'h0, 14'h0, 14'h0, 1'b0, 1'b1, ST_HALT);
        IR = 32'hF800_0000; mem_ready = 1'b1; run = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            n_checks++;
            if (obs !== tab[i]) $display("FAIL illegal cycle %0d: got %h want %h", i, obs, tab[i]);
            else n_pass++;
        end
        run = 1'b0;
        #2 clear = 1'b0;
        #1;
        e = ev(16'h0, 16'h0, 14'h0, 14'h0, 1'b0, 1'b0, ST_IDLE);
        n_checks++;
        if (obs !== e) $display("FAIL illegal_clear: got %h want %h", obs, e);
        else n_pass++;
        #1 clear = 1'b1;
        tick();
        n_checks++;
        if (obs !== e) $display("FAIL illegal_release: got %h want %h", obs, e);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        clear = 1'b0; run = 1'b0; mem_ready = 1'b0; IR = 32'h0;
        test_reset();
        test_or_exec();
        test_mem_wait();
        test_mul();
        test_back_to_back();
        test_illegal();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
